// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
//   Bundles the two requester ports (instruction fetch, load/store) and the
//   single-port memory bus that mem_port_arbiter sits between.
//
//   Parameters
//     ADDR_W  byte address width
//     DATA_W  data width; byte enables are DATA_W/8 bits
//
//   Modports
//     slave   arbiter view: sees requests and memory read data, drives grants,
//             responses and the memory command
//     master  environment view: requesters plus memory, the mirror of slave
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    // Instruction fetch port (read only)
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    // Load/store port
    logic              ls_req;
    logic              ls_we;
    logic [BE_W-1:0]   ls_be;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic              ls_gnt;
    logic              ls_rvalid;
    logic [DATA_W-1:0] ls_rdata;

    // Memory port
    logic              mem_req;
    logic              mem_we;
    logic [BE_W-1:0]   mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr,
        input  ls_req, ls_we, ls_be, ls_addr, ls_wdata,
        input  mem_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output ls_gnt, ls_rvalid, ls_rdata,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr,
        output ls_req, ls_we, ls_be, ls_addr, ls_wdata,
        output mem_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  ls_gnt, ls_rvalid, ls_rdata,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-port memory between instruction fetch (IF) and
//   load/store (LS). At most one request is granted per cycle; LS wins ties
//   unless IF has been denied STARVE_MAX cycles in a row. Read data comes back
//   MEM_LATENCY cycles after the grant and is steered to the port that issued
//   the read. A new grant may be issued every cycle (reads are pipelined).
//
//   Parameters
//     ADDR_W       byte address width
//     DATA_W       data width
//     MEM_LATENCY  cycles from mem_req to valid mem_rdata, >= 1
//     STARVE_MAX   consecutive IF denials before IF wins; 0 = IF always wins
//
//   Ports
//     clk   clock, rising edge
//     rst   reset, asynchronous, active-high; all outputs 0 while asserted
//     bus   mem_port_arbiter_if.slave: IF port, LS port and memory port
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1,
    parameter int STARVE_MAX  = 3
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
    } resp_t;

    logic [CNT_W-1:0] starve_cnt;
    logic             if_gnt;
    logic             ls_gnt;
    resp_t            push;
    resp_t            tail;
    resp_t            pipe [MEM_LATENCY];

    // -------------------------------------------------------------------------
    // Arbitration. Grants are combinational from the requests and the starve
    // counter, and are forced low while rst is held so nothing leaks out.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of a combinational block gets a default first;
        // any path that leaves one unassigned would infer a latch.
        if_gnt = 1'b0;
        ls_gnt = 1'b0;
        if (!rst) begin
            if (bus.if_req && bus.ls_req) begin
                if (starve_cnt == CNT_MAX) begin
                    if_gnt = 1'b1;
                end else begin
                    ls_gnt = 1'b1;
                end
            end else begin
                if_gnt = bus.if_req;
                ls_gnt = bus.ls_req;
            end
        end
    end

    // Counts consecutive cycles IF waited; with STARVE_MAX = 0 it never
    // leaves 0, so IF wins every tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!bus.if_req || if_gnt) begin
            // NOTE: state registers use non-blocking assignment so every
            // flop samples the pre-edge values of its neighbours.
            starve_cnt <= '0;
        end else if (starve_cnt != CNT_MAX) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Memory command: muxed from the granted port, all zero when idle.
    // -------------------------------------------------------------------------
    always_comb begin
        bus.mem_req   = if_gnt | ls_gnt;
        bus.mem_we    = 1'b0;
        bus.mem_be    = '0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (ls_gnt) begin
            bus.mem_we    = bus.ls_we;
            bus.mem_be    = bus.ls_be;
            bus.mem_addr  = bus.ls_addr;
            bus.mem_wdata = bus.ls_wdata;
        end else if (if_gnt) begin
            bus.mem_be    = {BE_W{1'b1}};
            bus.mem_addr  = bus.if_addr;
        end
    end

    // -------------------------------------------------------------------------
    // Response pipe: one {valid, owner} entry per cycle of memory latency.
    // Stores push an invalid entry, so they never raise ls_rvalid.
    // -------------------------------------------------------------------------
    always_comb begin
        push.valid = if_gnt | (ls_gnt & ~bus.ls_we);
        push.owner = ls_gnt ? OWN_LS : OWN_IF;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: this small pipe is reset (unlike a data RAM) because
            // dropping in-flight reads on reset depends on its valid bits.
            for (int i = 0; i < MEM_LATENCY; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= push;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign tail = pipe[MEM_LATENCY-1];

    // Read data is zeroed on the port that does not own the returning beat,
    // so a response can never appear on the wrong port.
    always_comb begin
        bus.if_gnt    = if_gnt;
        bus.ls_gnt    = ls_gnt;
        bus.if_rvalid = tail.valid && (tail.owner == OWN_IF);
        bus.ls_rvalid = tail.valid && (tail.owner == OWN_LS);
        bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : '0;
        bus.ls_rdata  = bus.ls_rvalid ? bus.mem_rdata : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Three arbiter instances share clk/rst:
//     dut_a  MEM_LATENCY=1, STARVE_MAX=3  (vector table, starvation)
//     dut_b  MEM_LATENCY=2, STARVE_MAX=3  (pipelined reads, reset mid-flight)
//     dut_c  MEM_LATENCY=1, STARVE_MAX=0  (IF fixed priority)
//   Inputs change 1 time unit after the rising edge; outputs are sampled on
//   the falling edge.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_a ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_b ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_c ();

    mem_port_arbiter #(.MEM_LATENCY(1), .STARVE_MAX(3)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    mem_port_arbiter #(.MEM_LATENCY(2), .STARVE_MAX(3)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
    mem_port_arbiter #(.MEM_LATENCY(1), .STARVE_MAX(0)) dut_c (.clk(clk), .rst(rst), .bus(bus_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: address 0x4 holds an instruction word, everything
    // else reads back as 0xC0DE0000 | addr[15:0].
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (addr == 32'h4) return 32'h0040_2083;
        return 32'hC0DE_0000 | {16'h0, addr[15:0]};
    endfunction

    // Memory models: data appears MEM_LATENCY cycles after mem_req.
    logic [31:0] b_stage;
    always @(posedge clk) begin
        bus_a.mem_rdata <= bus_a.mem_req ? mem_word(bus_a.mem_addr) : 32'h0;
        bus_c.mem_rdata <= bus_c.mem_req ? mem_word(bus_c.mem_addr) : 32'h0;
        b_stage         <= bus_b.mem_req ? mem_word(bus_b.mem_addr) : 32'h0;
        bus_b.mem_rdata <= b_stage;
    end

    // {if_gnt, ls_gnt, mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    //  if_rvalid, if_rdata, ls_rvalid, ls_rdata} = 138 bits
    function automatic logic [137:0] pack_exp(
        input logic ig, input logic lg, input logic mr, input logic mw,
        input logic [3:0] mb, input logic [31:0] ma, input logic [31:0] md,
        input logic irv, input logic [31:0] ird, input logic lrv, input logic [31:0] lrd);
        return {ig, lg, mr, mw, mb, ma, md, irv, ird, lrv, lrd};
    endfunction

    function automatic logic [137:0] snap_a();
        return {bus_a.if_gnt, bus_a.ls_gnt, bus_a.mem_req, bus_a.mem_we, bus_a.mem_be,
                bus_a.mem_addr, bus_a.mem_wdata, bus_a.if_rvalid, bus_a.if_rdata,
                bus_a.ls_rvalid, bus_a.ls_rdata};
    endfunction

    function automatic logic [137:0] snap_b();
        return {bus_b.if_gnt, bus_b.ls_gnt, bus_b.mem_req, bus_b.mem_we, bus_b.mem_be,
                bus_b.mem_addr, bus_b.mem_wdata, bus_b.if_rvalid, bus_b.if_rdata,
                bus_b.ls_rvalid, bus_b.ls_rdata};
    endfunction

    function automatic logic [137:0] snap_c();
        return {bus_c.if_gnt, bus_c.ls_gnt, bus_c.mem_req, bus_c.mem_we, bus_c.mem_be,
                bus_c.mem_addr, bus_c.mem_wdata, bus_c.if_rvalid, bus_c.if_rdata,
                bus_c.ls_rvalid, bus_c.ls_rdata};
    endfunction

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic         if_req;
        logic [31:0]  if_addr;
        logic         ls_req;
        logic         ls_we;
        logic [3:0]   ls_be;
        logic [31:0]  ls_addr;
        logic [31:0]  ls_wdata;
        logic [137:0] exp;
    } vec_t;

    vec_t vecs [10];

    task automatic drive_a(input vec_t v);
        bus_a.if_req   = v.if_req;
        bus_a.if_addr  = v.if_addr;
        bus_a.ls_req   = v.ls_req;
        bus_a.ls_we    = v.ls_we;
        bus_a.ls_be    = v.ls_be;
        bus_a.ls_addr  = v.ls_addr;
        bus_a.ls_wdata = v.ls_wdata;
    endtask

    task automatic idle_all();
        bus_a.if_req = 1'b0; bus_a.ls_req = 1'b0; bus_a.ls_we = 1'b0;
        bus_b.if_req = 1'b0; bus_b.ls_req = 1'b0; bus_b.ls_we = 1'b0;
        bus_c.if_req = 1'b0; bus_c.ls_req = 1'b0; bus_c.ls_we = 1'b0;
        bus_a.if_addr = '0; bus_a.ls_addr = '0; bus_a.ls_be = '0; bus_a.ls_wdata = '0;
        bus_b.if_addr = '0; bus_b.ls_addr = '0; bus_b.ls_be = '0; bus_b.ls_wdata = '0;
        bus_c.if_addr = '0; bus_c.ls_addr = '0; bus_c.ls_be = '0; bus_c.ls_wdata = '0;
    endtask

    logic [1:0] exp_gnt_a [8];

    initial begin
        total = 0;
        bad   = 0;

        //              if   if_addr       ls   we    be       ls_addr       ls_wdata
        vecs[0] = '{1'b0, 32'h0,  1'b0, 1'b0, 4'h0, 32'h0,  32'h0,
                    pack_exp(0, 0, 0, 0, 4'h0, 32'h0,  32'h0,        0, 32'h0,        0, 32'h0)};
        vecs[1] = '{1'b1, 32'h4,  1'b0, 1'b0, 4'h0, 32'h0,  32'h0,
                    pack_exp(1, 0, 1, 0, 4'hF, 32'h4,  32'h0,        0, 32'h0,        0, 32'h0)};
        vecs[2] = '{1'b0, 32'h0,  1'b1, 1'b0, 4'hF, 32'h10, 32'h0,
                    pack_exp(0, 1, 1, 0, 4'hF, 32'h10, 32'h0,        1, 32'h00402083, 0, 32'h0)};
        vecs[3] = '{1'b0, 32'h0,  1'b1, 1'b1, 4'h3, 32'h8,  32'hDEADBEEF,
                    pack_exp(0, 1, 1, 1, 4'h3, 32'h8,  32'hDEADBEEF, 0, 32'h0,        1, 32'hC0DE0010)};
        vecs[4] = '{1'b0, 32'h0,  1'b0, 1'b0, 4'h0, 32'h0,  32'h0,
                    pack_exp(0, 0, 0, 0, 4'h0, 32'h0,  32'h0,        0, 32'h0,        0, 32'h0)};
        vecs[5] = '{1'b1, 32'hC,  1'b1, 1'b0, 4'hF, 32'h14, 32'h0,
                    pack_exp(0, 1, 1, 0, 4'hF, 32'h14, 32'h0,        0, 32'h0,        0, 32'h0)};
        vecs[6] = '{1'b1, 32'h20, 1'b0, 1'b0, 4'h0, 32'h0,  32'h0,
                    pack_exp(1, 0, 1, 0, 4'hF, 32'h20, 32'h0,        0, 32'h0,        1, 32'hC0DE0014)};
        vecs[7] = '{1'b0, 32'h0,  1'b0, 1'b0, 4'h0, 32'h0,  32'h0,
                    pack_exp(0, 0, 0, 0, 4'h0, 32'h0,  32'h0,        1, 32'hC0DE0020, 0, 32'h0)};
        vecs[8] = '{1'b0, 32'h0,  1'b1, 1'b0, 4'hC, 32'h18, 32'h12345678,
                    pack_exp(0, 1, 1, 0, 4'hC, 32'h18, 32'h12345678, 0, 32'h0,        0, 32'h0)};
        vecs[9] = '{1'b0, 32'h0,  1'b0, 1'b0, 4'h0, 32'h0,  32'h0,
                    pack_exp(0, 0, 0, 0, 4'h0, 32'h0,  32'h0,        0, 32'h0,        1, 32'hC0DE0018)};

        // {if_gnt, ls_gnt} with both requesting and STARVE_MAX=3
        exp_gnt_a = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b10};

        // ---- Reset held with both requests high: every output 0 ----
        idle_all();
        rst = 1'b1;
        bus_a.if_req = 1'b1; bus_a.ls_req = 1'b1; bus_a.if_addr = 32'h4; bus_a.ls_addr = 32'h8;
        bus_a.ls_be = 4'hF; bus_a.ls_wdata = 32'h55;
        bus_b.if_req = 1'b1; bus_b.ls_req = 1'b1;
        bus_c.if_req = 1'b1; bus_c.ls_req = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_hold_a", snap_a(), '0);
        check("rst_hold_b", snap_b(), '0);
        check("rst_hold_c", snap_c(), '0);

        // ---- Release with requests low: outputs stay 0 ----
        @(posedge clk);
        #1;
        idle_all();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check($sformatf("rst_release_a%0d", i), snap_a(), '0);
            check($sformatf("rst_release_b%0d", i), snap_b(), '0);
        end

        // ---- Vector table on dut_a ----
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            drive_a(vecs[i]);
            @(negedge clk);
            check($sformatf("vec%0d", i), snap_a(), vecs[i].exp);
        end

        // ---- Starvation guard: both requesting continuously ----
        @(posedge clk);
        #1;
        bus_a.if_req = 1'b1; bus_a.if_addr = 32'h40;
        bus_a.ls_req = 1'b1; bus_a.ls_we = 1'b0; bus_a.ls_be = 4'hF; bus_a.ls_addr = 32'h44;
        bus_c.if_req = 1'b1; bus_c.if_addr = 32'h40;
        bus_c.ls_req = 1'b1; bus_c.ls_we = 1'b0; bus_c.ls_be = 4'hF; bus_c.ls_addr = 32'h44;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(posedge clk);
            @(negedge clk);
            check($sformatf("starve_a%0d", k), {bus_a.if_gnt, bus_a.ls_gnt}, exp_gnt_a[k]);
            check($sformatf("fixed_if_c%0d", k), {bus_c.if_gnt, bus_c.ls_gnt}, 2'b10);
        end
        @(posedge clk);
        #1;
        idle_all();

        // ---- Pipelined reads on dut_b, latency 2 ----
        @(posedge clk);
        #1;
        bus_b.if_req = 1'b1; bus_b.if_addr = 32'h8;
        @(negedge clk);
        check("pipe_c0_if_gnt", {bus_b.if_gnt, bus_b.ls_gnt, bus_b.mem_addr}, {2'b10, 32'h8});
        @(posedge clk);
        #1;
        bus_b.if_req = 1'b0;
        bus_b.ls_req = 1'b1; bus_b.ls_we = 1'b0; bus_b.ls_be = 4'hF; bus_b.ls_addr = 32'h10;
        @(negedge clk);
        check("pipe_c1_ls_gnt", {bus_b.ls_gnt, bus_b.mem_addr, bus_b.if_rvalid, bus_b.ls_rvalid},
              {1'b1, 32'h10, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        bus_b.ls_req = 1'b0;
        @(negedge clk);
        check("pipe_c2_if_resp", {bus_b.if_rvalid, bus_b.if_rdata, bus_b.ls_rvalid, bus_b.ls_rdata},
              {1'b1, 32'hC0DE0008, 1'b0, 32'h0});
        @(negedge clk);
        check("pipe_c3_ls_resp", {bus_b.if_rvalid, bus_b.if_rdata, bus_b.ls_rvalid, bus_b.ls_rdata},
              {1'b0, 32'h0, 1'b1, 32'hC0DE0010});
        @(negedge clk);
        check("pipe_c4_quiet", {bus_b.if_rvalid, bus_b.ls_rvalid}, 2'b00);

        // ---- Async reset pulse with two reads in flight ----
        @(posedge clk);
        #1;
        bus_b.if_req = 1'b1; bus_b.if_addr = 32'h8;
        @(posedge clk);
        #1;
        bus_b.if_req = 1'b0;
        bus_b.ls_req = 1'b1; bus_b.ls_we = 1'b0; bus_b.ls_be = 4'hF; bus_b.ls_addr = 32'h10;
        @(posedge clk);
        // IF response is at the tail now and the LS read is one stage behind.
        #1;
        check("inflight_before_rst", bus_b.if_rvalid, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_async_b", snap_b(), '0);
        check("rst_async_a", snap_a(), '0);
        #1;
        bus_b.ls_req = 1'b0;
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("no_rvalid_after_rst%0d", i), {bus_b.if_rvalid, bus_b.ls_rvalid}, 2'b00);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
